// File: rtl/kernel_pingpong_ctrl_pkg.sv
// Shared types, default sizes and sizing helpers for the double-buffered
// kernel loader.
package kernel_pingpong_ctrl_pkg;

  // Number of bits needed to hold the value v (at least 1).
  function automatic int unsigned nbits(input int unsigned v);
    int unsigned n;
    n = 1;
    while ((64'd1 << n) <= 64'(v)) n++;
    return n;
  endfunction

  function automatic int unsigned sq(input int unsigned v);
    return v * v;
  endfunction

  localparam int unsigned KPP_K_DIM  = 3;
  localparam int unsigned KPP_M_BITS = 16;
  localparam int unsigned KPP_K_BITS = nbits(KPP_K_DIM);

  typedef logic [KPP_M_BITS-1:0]  elem_t;
  typedef elem_t [KPP_K_DIM-1:0]  col_t;
  typedef elem_t [KPP_K_DIM-1:0][KPP_K_DIM-1:0] kmat_t;   // [row][col]

  typedef enum logic {FILL, DRAIN} kload_state_t;

endpackage

// File: rtl/kernel_pingpong_ctrl_if.sv
// Kernel loader buses.
//   in_*  : column stream (valid/ready, in_last ends a kernel);
//           in_data element r (bits r*M_BITS +: M_BITS) is row r.
//   out_* : whole-kernel handoff to the multiplier array;
//           out_data element [row][col] at bits (row*K_DIM+col)*M_BITS.
// Modports: in_master/in_slave for the stream, out_master/out_slave for
// the kernel handoff.
interface kernel_pingpong_ctrl_if
  import kernel_pingpong_ctrl_pkg::*;
#(
  parameter int unsigned K_DIM  = KPP_K_DIM,
  parameter int unsigned M_BITS = KPP_M_BITS
) ();

  logic                           in_valid;
  logic                           in_ready;
  logic                           in_last;
  logic [K_DIM*M_BITS-1:0]        in_data;

  logic                           out_valid;
  logic                           out_ready;
  logic [sq(K_DIM)*M_BITS-1:0]    out_data;
  logic [nbits(K_DIM)-1:0]        out_dim;

  modport in_master  (output in_valid, in_last, in_data, input in_ready);
  modport in_slave   (input in_valid, in_last, in_data, output in_ready);
  modport out_master (output out_valid, out_data, out_dim, input out_ready);
  modport out_slave  (input out_valid, out_data, out_dim, output out_ready);

endinterface

// File: rtl/kernel_pingpong_ctrl_bank.sv
// One K_DIM x K_DIM kernel bank.
//   i_wr       : write column i_col with i_col_data (rows already masked)
//   i_clr      : with i_wr, clear the whole matrix before the column write
//   i_commit   : mark bank full and store i_dim
//   i_release  : consumer took the kernel, mark bank empty
//   o_full/o_mat/o_dim : stored state
module kernel_bank
  import kernel_pingpong_ctrl_pkg::*;
#(
  parameter int unsigned K_DIM  = KPP_K_DIM,
  parameter int unsigned M_BITS = KPP_M_BITS,
  parameter int unsigned K_BITS = nbits(K_DIM)
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      i_wr,
  input  logic                                      i_clr,
  input  logic [K_BITS-1:0]                         i_col,
  input  logic [K_DIM-1:0][M_BITS-1:0]              i_col_data,
  input  logic                                      i_commit,
  input  logic [K_BITS-1:0]                         i_dim,
  input  logic                                      i_release,
  output logic                                      o_full,
  output logic [K_DIM-1:0][K_DIM-1:0][M_BITS-1:0]   o_mat,
  output logic [K_BITS-1:0]                         o_dim
);

  logic [K_DIM-1:0][K_DIM-1:0][M_BITS-1:0] r_mat;
  logic                                    r_full;
  logic [K_BITS-1:0]                       r_dim;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mat  <= '0;
      r_full <= 1'b0;
      r_dim  <= '0;
    end else begin
      if (i_wr) begin
        // Clear then overwrite: the later column assignment wins for its bits.
        if (i_clr) r_mat <= '0;
        for (int unsigned c = 0; c < K_DIM; c++) begin
          if (K_BITS'(c) == i_col) begin
            for (int unsigned r = 0; r < K_DIM; r++) r_mat[r][c] <= i_col_data[r];
          end
        end
      end
      if (i_commit) begin
        r_full <= 1'b1;
        r_dim  <= i_dim;
      end else if (i_release) begin
        r_full <= 1'b0;
      end
    end
  end

  assign o_full = r_full;
  assign o_mat  = r_mat;
  assign o_dim  = r_dim;

endmodule

// File: rtl/kernel_pingpong_ctrl.sv
// Double-buffered kernel loader. Columns arrive on s_in, are assembled into
// one of two banks, and completed kernels are handed out on m_out in order.
//   clk, rst  : clock, synchronous active-high reset
//   cfg_k_dim : kernel dimension, sampled on the first column of each kernel
//               (0 or >K_DIM means K_DIM)
//   s_in      : column stream slave
//   m_out     : kernel handoff master
//   err_len   : one-cycle pulse when a kernel is shorter or longer than dim
module kernel_pingpong_ctrl
  import kernel_pingpong_ctrl_pkg::*;
#(
  parameter int unsigned K_DIM  = KPP_K_DIM,
  parameter int unsigned M_BITS = KPP_M_BITS,
  parameter int unsigned K_BITS = nbits(K_DIM)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [K_BITS-1:0]     cfg_k_dim,
  kernel_pingpong_ctrl_if.in_slave   s_in,
  kernel_pingpong_ctrl_if.out_master m_out,
  output logic                  err_len
);

  kload_state_t      r_state;
  logic              r_wr_ptr;
  logic              r_rd_ptr;
  logic [K_BITS-1:0] r_col_cnt;
  logic [K_BITS-1:0] r_dim;
  logic              r_in_ready;
  logic              r_err_len;

  kload_state_t      w_state_nxt;
  logic [K_BITS-1:0] w_cfg_dim;
  logic [K_BITS-1:0] w_dim;
  logic [K_BITS-1:0] w_last_col;
  logic              w_beat;
  logic              w_first;
  logic              w_wr;
  logic              w_commit;
  logic              w_short;
  logic              w_long;
  logic              w_out_valid;
  logic              w_release;
  logic              w_wr_ptr_nxt;
  logic [1:0]        w_wr_b;
  logic [1:0]        w_commit_b;
  logic [1:0]        w_release_b;
  logic [1:0]        w_full;
  logic [1:0]        w_full_nxt;
  logic [K_DIM-1:0][M_BITS-1:0]            w_col;
  logic [1:0][K_DIM-1:0][K_DIM-1:0][M_BITS-1:0] w_mat;
  logic [1:0][K_BITS-1:0]                  w_bdim;

  always_comb begin
    w_cfg_dim = (cfg_k_dim == '0 || cfg_k_dim > K_BITS'(K_DIM)) ? K_BITS'(K_DIM) : cfg_k_dim;
    w_first   = (r_col_cnt == '0);
    w_dim     = w_first ? w_cfg_dim : r_dim;
    w_last_col = w_dim - K_BITS'(1);

    w_beat    = s_in.in_valid && r_in_ready;
    w_wr      = w_beat && (r_state == FILL);
    w_commit  = w_wr && (r_col_cnt == w_last_col);
    w_short   = w_wr && s_in.in_last && (r_col_cnt != w_last_col);
    w_long    = w_commit && !s_in.in_last;

    w_col = '0;
    for (int unsigned r = 0; r < K_DIM; r++) begin
      if (K_BITS'(r) < w_dim) w_col[r] = s_in.in_data[r*M_BITS +: M_BITS];
    end

    w_out_valid = r_rd_ptr ? w_full[1] : w_full[0];
    w_release   = w_out_valid && m_out.out_ready;

    w_wr_b      = {w_wr && r_wr_ptr, w_wr && !r_wr_ptr};
    w_commit_b  = {w_commit && r_wr_ptr, w_commit && !r_wr_ptr};
    w_release_b = {w_release && r_rd_ptr, w_release && !r_rd_ptr};
    w_full_nxt  = (w_full & ~w_release_b) | w_commit_b;
    w_wr_ptr_nxt = r_wr_ptr ^ w_commit;

    w_state_nxt = r_state;
    case (r_state)
      FILL:    if (w_long) w_state_nxt = DRAIN;
      DRAIN:   if (w_beat && s_in.in_last) w_state_nxt = FILL;
      default: w_state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= FILL;
      r_wr_ptr   <= 1'b0;
      r_rd_ptr   <= 1'b0;
      r_col_cnt  <= '0;
      r_dim      <= '0;
      r_in_ready <= 1'b0;
      r_err_len  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_wr_ptr  <= w_wr_ptr_nxt;
      r_err_len <= w_short || w_long;
      if (w_release) r_rd_ptr <= ~r_rd_ptr;
      if (w_wr) begin
        if (w_first) r_dim <= w_cfg_dim;
        r_col_cnt <= (s_in.in_last || w_commit) ? '0 : r_col_cnt + K_BITS'(1);
      end
      // Look ahead at next-cycle bank occupancy so ready is exact while registered.
      r_in_ready <= (w_state_nxt == DRAIN) || !w_full_nxt[w_wr_ptr_nxt];
    end
  end

  kernel_bank #(.K_DIM(K_DIM), .M_BITS(M_BITS), .K_BITS(K_BITS)) u_bank0 (
    .clk        (clk),
    .rst        (rst),
    .i_wr       (w_wr_b[0]),
    .i_clr      (w_first),
    .i_col      (r_col_cnt),
    .i_col_data (w_col),
    .i_commit   (w_commit_b[0]),
    .i_dim      (w_dim),
    .i_release  (w_release_b[0]),
    .o_full     (w_full[0]),
    .o_mat      (w_mat[0]),
    .o_dim      (w_bdim[0])
  );

  kernel_bank #(.K_DIM(K_DIM), .M_BITS(M_BITS), .K_BITS(K_BITS)) u_bank1 (
    .clk        (clk),
    .rst        (rst),
    .i_wr       (w_wr_b[1]),
    .i_clr      (w_first),
    .i_col      (r_col_cnt),
    .i_col_data (w_col),
    .i_commit   (w_commit_b[1]),
    .i_dim      (w_dim),
    .i_release  (w_release_b[1]),
    .o_full     (w_full[1]),
    .o_mat      (w_mat[1]),
    .o_dim      (w_bdim[1])
  );

  assign s_in.in_ready   = r_in_ready;
  assign m_out.out_valid = w_out_valid;
  assign m_out.out_data  = r_rd_ptr ? w_mat[1] : w_mat[0];
  assign m_out.out_dim   = r_rd_ptr ? w_bdim[1] : w_bdim[0];
  assign err_len         = r_err_len;

endmodule

// File: tb/tb_kernel_pingpong_ctrl.sv
// Bench for kernel_pingpong_ctrl: expected kernels are queued as their
// committing column is driven and compared when the DUT hands them out.
module tb_kernel_pingpong_ctrl;
  import kernel_pingpong_ctrl_pkg::*;

  localparam int K = 3;
  localparam int M = 16;
  typedef logic [K*K*M-1:0] mat_t;
  typedef logic [K*M-1:0]   colv_t;

  logic       clk;
  logic       rst;
  logic [1:0] cfg_k_dim;
  logic       err_len;

  int checks;
  int errors;
  int err_cnt;

  mat_t       sb_mat[$];
  logic [1:0] sb_dim[$];

  kernel_pingpong_ctrl_if #(.K_DIM(K), .M_BITS(M)) bus ();

  kernel_pingpong_ctrl #(.K_DIM(K), .M_BITS(M)) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_k_dim (cfg_k_dim),
    .s_in      (bus),
    .m_out     (bus),
    .err_len   (err_len)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timeout");
  end

  function automatic int eff_dim(input int cfg);
    return (cfg == 0 || cfg > K) ? K : cfg;
  endfunction

  function automatic mat_t mk_mat(input int base, input int d, input bit cst);
    mat_t m;
    m = '0;
    for (int r = 0; r < d; r++)
      for (int c = 0; c < d; c++)
        m[(r*K+c)*M +: M] = cst ? 16'(base) : 16'(base + c*10 + r);
    return m;
  endfunction

  // All rows carry data, including rows beyond dim that the DUT must mask.
  function automatic colv_t mk_col(input int base, input int c, input bit cst);
    colv_t v;
    for (int r = 0; r < K; r++) v[r*M +: M] = cst ? 16'(base) : 16'(base + c*10 + r);
    return v;
  endfunction

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic scoreboard_mon();
    forever begin
      @(negedge clk);
      if (!rst && err_len === 1'b1) err_cnt++;
      if (!rst && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
        checks++;
        if (sb_mat.size() == 0) begin
          errors++;
          $display("FAIL unexpected_kernel got=%h", bus.out_data);
        end else begin
          mat_t       em;
          logic [1:0] ed;
          em = sb_mat.pop_front();
          ed = sb_dim.pop_front();
          if (bus.out_data !== em) begin
            errors++;
            $display("FAIL kernel_data got=%h exp=%h", bus.out_data, em);
          end
          checks++;
          if (bus.out_dim !== ed) begin
            errors++;
            $display("FAIL kernel_dim got=%0d exp=%0d", bus.out_dim, ed);
          end
        end
      end
    end
  endtask

  task automatic drive_beat(input colv_t d, input bit last, output bit ok);
    int n;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    n = 0;
    @(negedge clk);
    while (bus.in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    ok = (bus.in_ready === 1'b1);
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL beat_accept_timeout in_ready=%b exp=1", bus.in_ready);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic send_kernel(input int base, input int nbeats, input int cfg, input bit cst);
    int d;
    bit ok;
    d = eff_dim(cfg);
    cfg_k_dim = 2'(cfg);
    for (int b = 0; b < nbeats; b++) begin
      if (b == d - 1 && nbeats >= d) begin
        sb_mat.push_back(mk_mat(base, d, cst));
        sb_dim.push_back(2'(d));
      end
      drive_beat(mk_col(base, b, cst), (b == nbeats - 1), ok);
      if (!ok) return;
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((sb_mat.size() != 0 || bus.out_valid === 1'b1) && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb_mat.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout pending=%0d exp=0", sb_mat.size());
    end
    sync();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_last = 1'b0;
    bus.in_data = '0;
    bus.out_ready = 1'b0;
    cfg_k_dim = 2'd3;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.in_ready !== 1'b0)  begin errors++; $display("FAIL rst_in_ready got=%b exp=0", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.out_data !== '0)    begin errors++; $display("FAIL rst_out_data got=%h exp=0", bus.out_data); end
    checks++; if (bus.out_dim !== 2'd0)   begin errors++; $display("FAIL rst_out_dim got=%0d exp=0", bus.out_dim); end
    checks++; if (err_len !== 1'b0)       begin errors++; $display("FAIL rst_err_len got=%b exp=0", err_len); end
    sync();
    rst = 1'b0;
    @(negedge clk);
    checks++; if (bus.in_ready !== 1'b0)  begin errors++; $display("FAIL rst_ready_early got=%b exp=0", bus.in_ready); end
    @(negedge clk);
    checks++; if (bus.in_ready !== 1'b1)  begin errors++; $display("FAIL rst_ready_rise got=%b exp=1", bus.in_ready); end
    sync();
  endtask

  task automatic test_basic();
    int e0;
    e0 = err_cnt;
    bus.out_ready = 1'b1;
    send_kernel(0, 3, 3, 1'b0);
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL basic_latency out_valid=%b exp=1", bus.out_valid); end
    wait_drain();
    checks++; if (err_cnt != e0) begin errors++; $display("FAIL basic_err got=%0d exp=%0d", err_cnt, e0); end
  endtask

  task automatic test_back_to_back();
    time  t0;
    mat_t ma, mb;
    ma = mk_mat(0, 3, 1'b0);
    mb = mk_mat(30, 3, 1'b0);
    bus.out_ready = 1'b0;
    t0 = $time;
    send_kernel(0, 3, 3, 1'b0);
    send_kernel(30, 3, 3, 1'b0);
    checks++;
    if ($time - t0 != 60) begin errors++; $display("FAIL b2b_cycles got=%0t exp=60", $time - t0); end
    @(negedge clk);
    checks++; if (bus.in_ready !== 1'b0)  begin errors++; $display("FAIL b2b_full_ready got=%b exp=0", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid got=%b exp=1", bus.out_valid); end
    checks++; if (bus.out_data !== ma)    begin errors++; $display("FAIL b2b_data_a got=%h exp=%h", bus.out_data, ma); end
    repeat (3) @(negedge clk);
    checks++; if (bus.out_data !== ma)    begin errors++; $display("FAIL b2b_hold_a got=%h exp=%h", bus.out_data, ma); end
    checks++; if (bus.in_ready !== 1'b0)  begin errors++; $display("FAIL b2b_hold_ready got=%b exp=0", bus.in_ready); end
    sync();
    bus.out_ready = 1'b1;
    sync();
    bus.out_ready = 1'b0;
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid_b got=%b exp=1", bus.out_valid); end
    checks++; if (bus.out_data !== mb)    begin errors++; $display("FAIL b2b_data_b got=%h exp=%h", bus.out_data, mb); end
    checks++; if (bus.in_ready !== 1'b1)  begin errors++; $display("FAIL b2b_ready_back got=%b exp=1", bus.in_ready); end
    sync();
    bus.out_ready = 1'b1;
    wait_drain();
  endtask

  task automatic test_reduced_dim();
    bus.out_ready = 1'b1;
    send_kernel(5, 2, 2, 1'b1);
    wait_drain();
    send_kernel(40, 3, 0, 1'b0);
    wait_drain();
  endtask

  task automatic test_short();
    int e0;
    e0 = err_cnt;
    bus.out_ready = 1'b1;
    send_kernel(70, 2, 3, 1'b0);
    repeat (2) @(negedge clk);
    checks++; if (err_cnt != e0 + 1)      begin errors++; $display("FAIL short_err got=%0d exp=%0d", err_cnt, e0 + 1); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL short_valid got=%b exp=0", bus.out_valid); end
    sync();
    send_kernel(100, 3, 3, 1'b0);
    wait_drain();
  endtask

  task automatic test_long();
    int  e0;
    time t0;
    e0 = err_cnt;
    bus.out_ready = 1'b1;
    t0 = $time;
    send_kernel(150, 5, 3, 1'b0);
    checks++;
    if ($time - t0 != 50) begin errors++; $display("FAIL long_drain_cycles got=%0t exp=50", $time - t0); end
    wait_drain();
    checks++; if (err_cnt != e0 + 1) begin errors++; $display("FAIL long_err got=%0d exp=%0d", err_cnt, e0 + 1); end
    send_kernel(200, 3, 3, 1'b0);
    wait_drain();
  endtask

  task automatic test_reset_mid();
    int e0;
    bit ok;
    e0 = err_cnt;
    bus.out_ready = 1'b1;
    cfg_k_dim = 2'd3;
    drive_beat(mk_col(90, 0, 1'b0), 1'b0, ok);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++; if (bus.in_ready !== 1'b0)  begin errors++; $display("FAIL midrst_ready got=%b exp=0", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got=%b exp=0", bus.out_valid); end
    sync();
    rst = 1'b0;
    send_kernel(50, 3, 3, 1'b0);
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL midrst_reload got=%b exp=1", bus.out_valid); end
    wait_drain();
    checks++; if (err_cnt != e0) begin errors++; $display("FAIL midrst_err got=%0d exp=%0d", err_cnt, e0); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    err_cnt = 0;
    rst = 1'b1;
    fork
      scoreboard_mon();
    join_none
    test_reset();
    test_basic();
    test_back_to_back();
    test_reduced_dim();
    test_short();
    test_long();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
